hs_sync_fifo: RTL and testbench
===============================

Name: hs_sync_fifo

Overview:
- Synchronous valid/ready buffer between the data-producing master stage and the consuming slave stage.
- Decouples producer bursts from consumer stalls so that neither side throttles the other until DEPTH entries are outstanding.
- Both sides use the team's valid/ready handshake rules, where a transfer occurs on a rising clk edge with valid && ready.
- The module is a single clock domain and uses no combinational paths from input to output on the data path.

Parameters:
- DATA_W, 8, width of each data beat.
- DEPTH, 4, number of storage entries. Must be a power of two and at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the fill counter. Derived; not to be overridden.

Ports:
- clk  input  1  sole clock; all logic updates on the rising edge.
- rst  input  1  asynchronous reset, active-high; deassertion is synchronous to clk externally.
- s_valid  input  1  upstream beat valid.
- s_ready  output  1  buffer can accept a beat.
- s_data  input  DATA_W  upstream beat payload.
- m_valid  output  1  buffer holds a beat for downstream.
- m_ready  input  1  downstream accepts the beat.
- m_data  output  DATA_W  head-of-buffer payload.
- level  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=1, any time, asynchronous):
  - wr_ptr=0, rd_ptr=0, level=0.
  - s_ready=0 while rst is high; s_ready=1 from the first cycle after release.
  - m_valid=0, m_data=0.
  - Storage contents are don't-care.
  - Reset mid-transfer discards all held beats; no beat is delivered after reset release unless it was pushed after release.
- Push = s_valid && s_ready. Pop = m_valid && m_ready. Both are evaluated at the same edge.
- s_ready = (level != DEPTH). It is derived from registered level only and never depends on m_ready, so a full buffer does not pass through.
- m_valid = (level != 0). m_data = mem[rd_ptr], presented from registered storage.
- Latency: a beat pushed at edge N is visible on m_valid/m_data after edge N. Minimum one cycle, no bypass.
- Throughput: one push and one pop per cycle sustained when 0 < level < DEPTH.
- Level update:
  - Push only: level + 1.
  - Pop only: level - 1.
  - Push and pop together: level unchanged; write at wr_ptr and read advance at rd_ptr both occur.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Empty (level=0): m_valid=0; m_ready is ignored. A push alone is legal.
- Full (level=DEPTH): s_ready=0; s_valid is ignored. A pop makes s_ready=1 on the next cycle.
- Stability: while m_valid && !m_ready, m_data and m_valid hold constant.
- Upstream may drop s_valid at any time when s_ready=0. The buffer does not require valid to be held.
- Ordering is strict FIFO. No beat is dropped or duplicated.

Optional Feature:
- Macro: HS_FIFO_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt, 16 bits.
  - Counts cycles with m_valid && !m_ready, saturating at 16'hFFFF.
  - Cleared by rst.
- Undefined:
  - Port and counter are absent.
  - Behaviour is otherwise identical.

Decomposition:
- Package hs_pkg holds:
  - Default DATA_W constant (8).
  - Default DEPTH constant (4).
  - A function for computing pointer width.
- One natural sub-module: hs_fifo_mem.
  - DEPTH x DATA_W register array.
  - Write port: wr_en, wr_addr, wr_data.
  - Asynchronous read: rd_addr to rd_data.
- All control, including pointers, level and the optional stall counter, stays in hs_sync_fifo.

Test Plan:
- Reset then idle: hold rst=1 for 10 cycles, release, s_valid=0 -> s_ready=1, m_valid=0, level=0 continuously.
- Fill to full: m_ready=0; push 8'h01, 8'h02, 8'h03, 8'h04 on consecutive cycles -> level steps 1,2,3,4; s_ready=0 after the 4th push; a 5th s_valid=1 with 8'h05 is not accepted and level stays 4.
- Drain: from full with m_ready=1 -> m_data sequence 01,02,03,04 on four consecutive cycles; level steps 3,2,1,0; m_valid=0 after the last pop; s_ready=1 after the first pop.
- Simultaneous push/pop: level=2, s_valid=1 and m_ready=1 for 20 cycles with random 0..15 data -> level stays 2; output sequence equals input sequence delayed by 2 beats; pointers wrap 5 times with no corruption.
- Random stall: s_valid toggled every 3rd cycle and m_ready randomly 50% for 1000 cycles with random 0..15 data -> scoreboard shows zero loss or reorder; level is never above 4 or below 0; m_data is stable whenever m_valid && !m_ready.
- Reset mid-operation: level=3 with stalls, assert rst asynchronously mid-cycle -> m_valid=0 and level=0 immediately; after release, the first delivered beat is the first one pushed after release. With HS_FIFO_STALL_CNT_EN defined, stall_cnt reads 0 after reset and equals the stall cycles counted in the previous scenario before reset.

Source files
------------

// File: rtl/hs_sync_fifo_pkg.sv
// hs_pkg: shared defaults and pointer-width helper for the hs_sync_fifo slice.
package hs_pkg;
    localparam int HS_DATA_W = 8;
    localparam int HS_DEPTH  = 4;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/hs_sync_fifo_mem.sv
// hs_fifo_mem: DEPTH x DATA_W register array, one synchronous write port, asynchronous read.
module hs_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_addr] = wr_data;
    end

    // Storage is deliberately unreset; only the control in the top is cleared.
    always_ff @(posedge clk) mem_q <= mem_d;

    assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/hs_sync_fifo.sv
// hs_sync_fifo: registered valid/ready FIFO with no input-to-output data path.
// Defining HS_FIFO_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module hs_sync_fifo
    import hs_pkg::*;
#(
    parameter int DATA_W = HS_DATA_W,
    parameter int DEPTH  = HS_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
`ifdef HS_FIFO_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic [CNT_W-1:0]  level
);
    localparam int PTR_W = ptr_w(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] rd_data;
    logic              push, pop;

    // Ready depends only on registered level (and reset), never on m_ready.
    assign s_ready = !rst && (level_q != CNT_W'(DEPTH));
    assign m_valid = (level_q != '0);
    assign m_data  = m_valid ? rd_data : '0;
    assign level   = level_q;
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

`ifdef HS_FIFO_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb stall_cnt_d = (m_valid && !m_ready && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

    hs_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(PTR_W)) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (s_data),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );
endmodule

// File: tb/tb_hs_sync_fifo.sv
// tb_hs_sync_fifo: directed scoreboard bench for hs_sync_fifo (DEPTH=4, DATA_W=8).
module tb_hs_sync_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = '0;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic [2:0] level;
`ifdef HS_FIFO_STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] stall_model = '0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] q[$];
    logic       sv_tog;

    always #5 clk = ~clk;

    hs_sync_fifo dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
`ifdef HS_FIFO_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .level   (level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive, check against the queue model, update model, advance one cycle.
    task automatic cycle(input logic sv, input logic [7:0] sd, input logic mr);
        logic acc, pp;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        #1;
        chk("level", 32'(level), 32'(q.size()));
        chk("s_ready", 32'(s_ready), 32'(q.size() != 4));
        chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("m_data", 32'(m_data), 32'(q[0]));
`ifdef HS_FIFO_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(stall_model));
        if (q.size() != 0 && !mr && stall_model != 16'hFFFF) stall_model++;
`endif
        acc = sv && q.size() != 4;
        pp  = mr && q.size() != 0;
        if (pp) void'(q.pop_front());
        if (acc) q.push_back(sd);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset then idle
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        rst = 1'b0;
        repeat (5) cycle(1'b0, 8'h00, 1'b0);

        // Fill to full, then a refused fifth beat
        for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0);
        cycle(1'b1, 8'h05, 1'b0);
        chk("full_level", 32'(level), 32'd4);

        // Drain
        repeat (4) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("drain_empty", 32'(m_valid), 32'd0);

        // Simultaneous push/pop at level 2
        cycle(1'b1, 8'h0A, 1'b0);
        cycle(1'b1, 8'h0B, 1'b0);
        repeat (20) cycle(1'b1, 8'($urandom_range(0, 15)), 1'b1);
        chk("pp_level", 32'(level), 32'd2);
        repeat (3) cycle(1'b0, 8'h00, 1'b1);

        // Random stall
        sv_tog = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (i % 3 == 0) sv_tog = ~sv_tog;
            cycle(sv_tog, 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        repeat (6) cycle(1'b0, 8'h00, 1'b1);

        // Reset mid-operation at level 3 with stalls
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
`ifdef HS_FIFO_STALL_CNT_EN
        chk("stall_pre_rst", 32'(stall_cnt), 32'(stall_model));
`endif
        #3 rst = 1'b1;
        #1;
        chk("arst_m_valid", 32'(m_valid), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_s_ready", 32'(s_ready), 32'd0);
        chk("arst_m_data", 32'(m_data), 32'd0);
`ifdef HS_FIFO_STALL_CNT_EN
        chk("arst_stall", 32'(stall_cnt), 32'd0);
        stall_model = '0;
`endif
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 8'hA5, 1'b0);
        cycle(1'b1, 8'h5A, 1'b0);
        chk("post_rst_head", 32'(m_data), 32'hA5);
        repeat (3) cycle(1'b0, 8'h00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
